ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester arbiter sharing the single 16-bit, 25-bit-word-addressed RAM command port between the SD-card boot loader (port 0) and a runtime client such as a sprite/frame fetcher (port 1). Latches one request at a time, forwards it to the RAM controller, and returns the controller's `op_begun` acknowledge to the winning requester only. Routes returned read data to its originator through an in-order owner-tag FIFO.

## Interface
Parameters:
- `READ_DEPTH`, 4: maximum outstanding reads; power of two, 2..16.
- `ADDR_W`, 25: word address width.

Ports:
- `clk50`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `r0_req` / `r1_req`  in  1  request; held high until the matching `op_begun` pulse
- `r0_we` / `r1_we`  in  1  1 = write, 0 = read; stable while `req` is high
- `r0_address` / `r1_address`  in  ADDR_W  word address
- `r0_data` / `r1_data`  in  16  write data
- `r0_op_begun` / `r1_op_begun`  out  1  acknowledge pulse; request accepted by RAM
- `r0_rdata` / `r1_rdata`  out  16  read data, valid with `rvalid`
- `r0_rvalid` / `r1_rvalid`  out  1  read-return strobe
- `ram_req`  out  1  command valid to RAM controller
- `ram_we`  out  1  latched write enable
- `ram_address`  out  ADDR_W  latched address
- `ram_wdata`  out  16  latched write data
- `ram_op_begun`  in  1  controller accepted the current command
- `ram_rdata`  in  16  read data
- `ram_rvalid`  in  1  read data strobe, in issue order
- `arb_error`  out  1  sticky: `ram_rvalid` arrived with no outstanding read

## Operation
- States: IDLE, BUSY0, BUSY1.
- IDLE: eligible requester = `req` high AND (`we`=1 OR tag count < READ_DEPTH). Pick winner per arbitration policy; latch `we`/address/data into command registers; go to BUSYn. Stay in IDLE if none is eligible.
- BUSYn: `ram_req`=1. On `ram_op_begun`=1:
  - `rn_op_begun`=1 in the same cycle (combinational from `ram_op_begun` and state).
  - If a read, push tag n.
  - Next state IDLE.
- Requesters drop `req` the cycle after `op_begun`. The arbiter does not re-sample a requester during the cycle in which it acknowledges it.
- Read return: on `ram_rvalid`, pop head tag; pulse `rt_rvalid` with `rt_rdata`=`ram_rdata`. The other port's `rvalid` stays 0. `rdata` outputs are driven from `ram_rdata` unconditionally.
- Tag FIFO push and pop in the same cycle: count unchanged, both occur.
- `ram_rvalid` with empty FIFO: data dropped, no `rvalid` pulse, `arb_error` set until reset.
- Writes are never blocked by a full tag FIFO.
- Port-1 reads issued after port-0 writes to the same address observe the written data, because the command port is serialized.

## Timing
- Reset values:
  - state IDLE
  - `ram_req`, `ram_we`, all `op_begun`/`rvalid` = 0
  - `ram_address`, `ram_wdata` = 0
  - tag FIFO empty, `arb_error` = 0
  - round-robin pointer = port 0
- Latency: `req` sampled in IDLE at cycle N; `ram_req` high at N+1; earliest `op_begun` at N+1.
- Throughput: at most one command per 2 cycles.
- Read return: `rvalid` is combinational from `ram_rvalid`, 0 cycles added.
- Reset mid-operation: outstanding command abandoned, `ram_req` low the next cycle, tags cleared, late read returns ignored without setting `arb_error`. The error-suppression window lasts until the first new read is issued.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin. On simultaneous eligible requests, the port not granted last wins. The pointer updates on every `op_begun`.
- `RAM_ARB_RR_EN` undefined: fixed priority, port 0 always wins. Port 1 can starve while the loader streams, which is acceptable during boot.

## Test plan
- Single write: `r0` write addr 0x000010, data 0xBEEF; controller acks 2 cycles later. Expect `ram_address`=0x000010, `ram_wdata`=0xBEEF, exactly one `r0_op_begun` pulse, `ram_req` low the following cycle.
- Simultaneous requests, both ports writing, held for 4 grants. Fixed build: grants 0,0,0,0. RR build: grants 0,1,0,1.
- Four `r1` reads acked back to back, a fifth held. Expect no fifth `ram_req` until the first `ram_rvalid` arrives. A concurrent `r0` write is granted while reads are blocked.
- Interleaved reads: `r0` reads addr 0x5, then `r1` reads addr 0x9; returns 0x1111 then 0x2222. Expect `r0_rvalid` with 0x1111, then `r1_rvalid` with 0x2222.
- Spurious `ram_rvalid` with empty FIFO: no `rvalid` pulse, `arb_error`=1 and held; cleared by reset.
- Reset asserted while in BUSY1 with 2 reads outstanding: `ram_req`=0 next cycle, subsequent returns produce no `rvalid` and no error, and the next command is accepted normally.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port RAM command arbiter with in-order read-owner tag FIFO
// Build option: RAM_ARB_RR_EN selects round-robin arbitration (default fixed priority, port 0 wins).
module ram_port_arbiter #(
    parameter int READ_DEPTH = 4,
    parameter int ADDR_W     = 25
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [15:0]       r0_data,
    output logic              r0_op_begun,
    output logic [15:0]       r0_rdata,
    output logic              r0_rvalid,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [15:0]       r1_data,
    output logic              r1_op_begun,
    output logic [15:0]       r1_rdata,
    output logic              r1_rvalid,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [15:0]       ram_wdata,
    input  logic              ram_op_begun,
    input  logic [15:0]       ram_rdata,
    input  logic              ram_rvalid,
    output logic              arb_error
);
    localparam int PW = $clog2(READ_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t                state;
    logic [READ_DEPTH-1:0] tag_mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         tag_count;
    logic                  suppress;
`ifdef RAM_ARB_RR_EN
    logic                  rr_ptr;
`endif

    logic elig0, elig1, pick1, push, pop, head;

    always_comb begin
        elig0 = r0_req && (r0_we || (tag_count < CW'(READ_DEPTH)));
        elig1 = r1_req && (r1_we || (tag_count < CW'(READ_DEPTH)));
`ifdef RAM_ARB_RR_EN
        pick1 = elig1 && (!elig0 || rr_ptr);
`else
        pick1 = elig1 && !elig0;
`endif
        push        = ram_op_begun && (state != IDLE) && !ram_we;
        pop         = ram_rvalid && (tag_count != '0);
        head        = tag_mem[rd_ptr];
        r0_op_begun = ram_op_begun && (state == BUSY0);
        r1_op_begun = ram_op_begun && (state == BUSY1);
        r0_rvalid   = pop && !head;
        r1_rvalid   = pop && head;
        r0_rdata    = ram_rdata;
        r1_rdata    = ram_rdata;
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state       <= IDLE;
            ram_req     <= 1'b0;
            ram_we      <= 1'b0;
            ram_address <= '0;
            ram_wdata   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_count   <= '0;
            arb_error   <= 1'b0;
            // Returns for reads abandoned by reset must not flag an error.
            suppress    <= 1'b1;
`ifdef RAM_ARB_RR_EN
            rr_ptr      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        ram_req     <= 1'b1;
                        ram_we      <= pick1 ? r1_we : r0_we;
                        ram_address <= pick1 ? r1_address : r0_address;
                        ram_wdata   <= pick1 ? r1_data : r0_data;
                        state       <= pick1 ? BUSY1 : BUSY0;
                    end
                end
                BUSY0, BUSY1: begin
                    if (ram_op_begun) begin
                        ram_req <= 1'b0;
                        state   <= IDLE;
`ifdef RAM_ARB_RR_EN
                        rr_ptr  <= (state == BUSY0);
`endif
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                tag_mem[wr_ptr] <= (state == BUSY1);
                wr_ptr          <= wr_ptr + 1'b1;
                suppress        <= 1'b0;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   tag_count <= tag_count + 1'b1;
                2'b01:   tag_count <= tag_count - 1'b1;
                default: tag_count <= tag_count;
            endcase

            if (ram_rvalid && (tag_count == '0) && !suppress)
                arb_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed and randomized bench for ram_port_arbiter with a queue-based reference model
module tb_ram_port_arbiter;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 25;

    logic              clk50 = 1'b0;
    logic              reset = 1'b1;
    logic              r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [ADDR_W-1:0] r0_address = '0, r1_address = '0;
    logic [15:0]       r0_data = '0, r1_data = '0;
    logic              r0_op_begun, r1_op_begun, r0_rvalid, r1_rvalid;
    logic [15:0]       r0_rdata, r1_rdata;
    logic              ram_req, ram_we;
    logic [ADDR_W-1:0] ram_address;
    logic [15:0]       ram_wdata;
    logic              ram_op_begun = 1'b0;
    logic [15:0]       ram_rdata = '0;
    logic              ram_rvalid = 1'b0;
    logic              arb_error;

    ram_port_arbiter #(.READ_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk50(clk50), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_address(r0_address), .r0_data(r0_data),
        .r0_op_begun(r0_op_begun), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_we(r1_we), .r1_address(r1_address), .r1_data(r1_data),
        .r1_op_begun(r1_op_begun), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
        .ram_req(ram_req), .ram_we(ram_we), .ram_address(ram_address), .ram_wdata(ram_wdata),
        .ram_op_begun(ram_op_begun), .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid),
        .arb_error(arb_error)
    );

    always #10 clk50 = ~clk50;

    int checks = 0;
    int errors = 0;

    // Reference model: owners of outstanding reads, sticky error, post-reset suppression, last grant.
    int tagq[$];
    bit m_err = 1'b0;
    bit m_sup = 1'b1;
    int m_last = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    function automatic int winner();
        bit e0 = r0_req && (r0_we || tagq.size() < DEPTH);
        bit e1 = r1_req && (r1_we || tagq.size() < DEPTH);
        if (e0 && e1) begin
`ifdef RAM_ARB_RR_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        r0_req = 1'b0; r1_req = 1'b0; ram_op_begun = 1'b0; ram_rvalid = 1'b0;
        tick();
        chk("reset_ram_req", ram_req, 0);
        tick();
        reset = 1'b0;
        tagq.delete();
        m_err = 1'b0; m_sup = 1'b1; m_last = 1;
    endtask

    task automatic grant(input int p, input int dly, input bit drop);
        int n = 0;
        logic exp_we;
        logic [ADDR_W-1:0] exp_addr;
        logic [15:0] exp_data;
        while (!ram_req && n < 20) begin tick(); n++; end
        chk("ram_req_rise", ram_req, 1);
        exp_we   = p ? r1_we : r0_we;
        exp_addr = p ? r1_address : r0_address;
        exp_data = p ? r1_data : r0_data;
        chk("ram_we", ram_we, exp_we);
        chk("ram_address", ram_address, exp_addr);
        if (exp_we) chk("ram_wdata", ram_wdata, exp_data);
        for (int d = 0; d < dly; d++) begin
            chk("early_op_begun", {r1_op_begun, r0_op_begun}, 0);
            tick();
        end
        ram_op_begun = 1'b1;
        #1;
        chk("op_begun", {r1_op_begun, r0_op_begun}, (p == 1) ? 2 : 1);
        if (!exp_we) begin tagq.push_back(p); m_sup = 1'b0; end
        m_last = p;
        tick();
        ram_op_begun = 1'b0;
        if (drop) begin if (p == 1) r1_req = 1'b0; else r0_req = 1'b0; end
        chk("ram_req_fall", ram_req, 0);
        chk("op_begun_single", {r1_op_begun, r0_op_begun}, 0);
    endtask

    task automatic ret(input logic [15:0] data);
        int owner;
        ram_rvalid = 1'b1;
        ram_rdata  = data;
        #1;
        if (tagq.size() > 0) begin
            owner = tagq.pop_front();
            chk("rvalid_route", {r1_rvalid, r0_rvalid}, (owner == 1) ? 2 : 1);
            chk("rdata", (owner == 1) ? r1_rdata : r0_rdata, data);
        end else begin
            chk("rvalid_none", {r1_rvalid, r0_rvalid}, 0);
            if (!m_sup) m_err = 1'b1;
        end
        tick();
        ram_rvalid = 1'b0;
        chk("arb_error", arb_error, m_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        int exp2 [4];
`ifdef RAM_ARB_RR_EN
        exp2 = '{0, 1, 0, 1};
`else
        exp2 = '{0, 0, 0, 0};
`endif
        do_reset();
        chk("rst_ram_address", ram_address, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_arb_error", arb_error, 0);
        chk("rst_strobes", {r1_op_begun, r0_op_begun, r1_rvalid, r0_rvalid}, 0);

        // Single write, acked two cycles after ram_req.
        r0_req = 1'b1; r0_we = 1'b1; r0_address = 25'h000010; r0_data = 16'hBEEF;
        grant(0, 2, 1);
        chk("single_write_addr", ram_address, 25'h000010);
        chk("single_write_data", ram_wdata, 16'hBEEF);

        // Both ports writing continuously for four grants.
        do_reset();
        r0_req = 1'b1; r0_we = 1'b1; r0_address = 25'h100; r0_data = 16'h0A0A;
        r1_req = 1'b1; r1_we = 1'b1; r1_address = 25'h200; r1_data = 16'h1B1B;
        for (int i = 0; i < 4; i++) grant(exp2[i], 0, 0);
        r0_req = 1'b0; r1_req = 1'b0;
        tick();

        // Fill the tag FIFO from port 1; fifth read must wait for a return.
        r1_req = 1'b1; r1_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r1_address = ADDR_W'(32'h40 + i);
            grant(1, 0, 0);
        end
        r1_address = 25'h44;
        for (int i = 0; i < 3; i++) begin tick(); chk("full_blocks_read", ram_req, 0); end
        r0_req = 1'b1; r0_we = 1'b1; r0_address = 25'h77; r0_data = 16'hCAFE;
        grant(0, 1, 1);
        for (int i = 0; i < 2; i++) begin tick(); chk("full_still_blocked", ram_req, 0); end
        ret(16'hA001);
        grant(1, 0, 1);
        for (int i = 0; i < 4; i++) ret(16'hA002 + 16'(i));

        // Interleaved reads from both ports return in issue order.
        r0_req = 1'b1; r0_we = 1'b0; r0_address = 25'h5;
        grant(0, 0, 1);
        r1_req = 1'b1; r1_we = 1'b0; r1_address = 25'h9;
        grant(1, 1, 1);
        ret(16'h1111);
        ret(16'h2222);

        // Spurious return with nothing outstanding sets a sticky error.
        ret(16'h3333);
        tick(); tick();
        chk("arb_error_sticky", arb_error, 1);
        do_reset();
        chk("arb_error_cleared", arb_error, 0);

        // Reset in BUSY1 with two reads outstanding.
        r1_req = 1'b1; r1_we = 1'b0; r1_address = 25'h20;
        grant(1, 0, 0);
        r1_address = 25'h21;
        grant(1, 0, 0);
        r1_address = 25'h22;
        w = 0;
        while (!ram_req && w < 20) begin tick(); w++; end
        chk("busy1_reached", ram_req, 1);
        reset = 1'b1; r1_req = 1'b0;
        tick();
        chk("mid_reset_ram_req", ram_req, 0);
        reset = 1'b0;
        tagq.delete(); m_err = 1'b0; m_sup = 1'b1; m_last = 1;
        ret(16'hDEAD);
        ret(16'hBEAD);
        r0_req = 1'b1; r0_we = 1'b1; r0_address = 25'h33; r0_data = 16'h5A5A;
        grant(0, 0, 1);
        r0_req = 1'b1; r0_we = 1'b0; r0_address = 25'h33;
        grant(0, 0, 1);
        ret(16'h5A5A);

        // Randomized traffic against the model.
        for (int it = 0; it < 80; it++) begin
            if (tagq.size() > 0 && $urandom_range(2) == 0) begin
                ret(16'($urandom));
            end else begin
                r0_req = 1'($urandom_range(1)); r0_we = 1'($urandom_range(1));
                r0_address = ADDR_W'($urandom); r0_data = 16'($urandom);
                r1_req = 1'($urandom_range(1)); r1_we = 1'($urandom_range(1));
                r1_address = ADDR_W'($urandom); r1_data = 16'($urandom);
                for (int k = 0; k < 2; k++) begin
                    w = winner();
                    if (w < 0) break;
                    grant(w, $urandom_range(2), 1);
                end
                r0_req = 1'b0; r1_req = 1'b0;
                tick();
                chk("idle_after_burst", ram_req, 0);
            end
        end
        while (tagq.size() > 0) ret(16'($urandom));
        chk("final_arb_error", arb_error, m_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
